// File: rtl/fwd_lkp_arb.sv
`default_nettype none
// ============================================================================
// Module      : fwd_lkp_arb
// Description : Round-robin arbiter for the single read port of the
//               forwarding lookup table. Issues one lookup per cycle, tracks
//               each lookup through the fixed table read latency, and returns
//               the result to the requester that issued it.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_lkp_arb #(
  parameter int NREQ   = 4,
  parameter int AW     = 8,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lkp_en,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*AW-1:0]  req_addr,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rsp_vld,
  output logic [DW-1:0]       rsp_data,
  output logic                fwd_rden,
  output logic [AW-1:0]       fwd_addr,
  input  logic [DW-1:0]       fwd_data,
  output logic                busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;
  logic [PW-1:0]   win_idx;
  logic            win_found;
  int              sel;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt_c;
  logic [AW-1:0]   win_addr;
  logic [AW-1:0]   addr_hold;
  logic [RD_LAT:0] stg_vld;
  logic [PW-1:0]   stg_idx [RD_LAT+1];

  // No new grants while frozen or while reset is held.
  assign elig = req & {NREQ{lkp_en & rst_n}};

  // Pick the first eligible requester scanning upward from the pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sel       = 0;
    for (int k = 0; k < NREQ; k++) begin
      sel = (int'(ptr) + k) % NREQ;
      if (!win_found && elig[sel]) begin
        win_found = 1'b1;
        win_idx   = PW'(sel);
      end
    end
  end

  // Decode the winner into the grant vector and select its address.
  always_comb begin
    gnt_c    = '0;
    win_addr = addr_hold;
    for (int i = 0; i < NREQ; i++) begin
      if (win_found && (win_idx == PW'(i))) begin
        gnt_c[i] = 1'b1;
        win_addr = req_addr[i*AW +: AW];
      end
    end
  end

  assign ptr_nxt  = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  assign gnt      = gnt_c;
  assign fwd_rden = win_found;
  assign fwd_addr = win_addr;

  // Advance the round-robin pointer past each winner; remember its address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      addr_hold <= '0;
    end else if (win_found) begin
      ptr       <= ptr_nxt;
      addr_hold <= win_addr;
    end
  end

  // Tag pipeline: one {valid, index} slot per cycle of table latency plus one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_vld <= '0;
      for (int k = 0; k <= RD_LAT; k++) begin
        stg_idx[k] <= '0;
      end
    end else begin
      stg_vld    <= {stg_vld[RD_LAT-1:0], win_found};
      stg_idx[0] <= win_idx;
      for (int k = 1; k <= RD_LAT; k++) begin
        stg_idx[k] <= stg_idx[k-1];
      end
    end
  end

  // Capture table data on the edge that moves the tag into the final stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_data <= '0;
    end else if (stg_vld[RD_LAT-1]) begin
      rsp_data <= fwd_data;
    end
  end

  // Busy mirrors "some tag stage will be valid next cycle".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else begin
      busy <= win_found | (|stg_vld[RD_LAT-1:0]);
    end
  end

  // Steer the response-valid pulse to the requester held in the final stage.
  always_comb begin
    rsp_vld = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (stg_vld[RD_LAT] && (stg_idx[RD_LAT] == PW'(i))) begin
        rsp_vld[i] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fwd_lkp_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_lkp_arb
// Description : Self-checking bench for fwd_lkp_arb (NREQ=4, RD_LAT=1) with
//               directed scenarios followed by randomized traffic, compared
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_lkp_arb;

  localparam int NREQ   = 4;
  localparam int AW     = 8;
  localparam int DW     = 16;
  localparam int RD_LAT = 1;

  logic                clk;
  logic                rst_n;
  logic                lkp_en;
  logic [NREQ-1:0]     req;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     rsp_vld;
  logic [DW-1:0]       rsp_data;
  logic                fwd_rden;
  logic [AW-1:0]       fwd_addr;
  logic [DW-1:0]       fwd_data;
  logic                busy;

  fwd_lkp_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .lkp_en(lkp_en), .req(req), .req_addr(req_addr),
    .gnt(gnt), .rsp_vld(rsp_vld), .rsp_data(rsp_data), .fwd_rden(fwd_rden),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table model: fixed contents, one-cycle registered read.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (fwd_rden) fwd_data <= mem[fwd_addr];
  end

  // Reference model state: outstanding lookups as {grant cycle, requester, data}.
  typedef struct { int g; int idx; logic [DW-1:0] d; } lkp_t;
  lkp_t        inflight [$];
  int          m_ptr;
  int          cyc;
  logic [DW-1:0] m_last;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance model.
  task automatic step(input logic r, input logic en, input logic [NREQ-1:0] rq,
                      input logic [NREQ*AW-1:0] ad, input bit do_chk);
    int win;
    logic [NREQ-1:0] el;
    logic [NREQ-1:0] e_gnt;
    logic [NREQ-1:0] e_rsp;
    logic [AW-1:0]   waddr;
    bit              e_busy;
    @(negedge clk);
    rst_n = r; lkp_en = en; req = rq; req_addr = ad;
    #2;
    el  = (r && en) ? rq : '0;
    win = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (win < 0 && el[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
    end
    e_gnt = '0;
    waddr = '0;
    if (win >= 0) begin
      e_gnt[win] = 1'b1;
      waddr = ad[win*AW +: AW];
    end
    while (inflight.size() > 0 && inflight[0].g + RD_LAT + 1 < cyc) void'(inflight.pop_front());
    e_rsp  = '0;
    e_busy = 0;
    foreach (inflight[i]) begin
      if (inflight[i].g < cyc) e_busy = 1;
      if (inflight[i].g + RD_LAT + 1 == cyc) begin
        e_rsp[inflight[i].idx] = 1'b1;
        m_last = inflight[i].d;
      end
    end
    if (do_chk) begin
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("fwd_rden", 32'(fwd_rden), 32'(win >= 0));
      if (win >= 0) chk("fwd_addr", 32'(fwd_addr), 32'(waddr));
      chk("rsp_vld", 32'(rsp_vld), 32'(e_rsp));
      chk("rsp_data", 32'(rsp_data), 32'(m_last));
      chk("busy", 32'(busy), 32'(e_busy));
    end
    if (!r) begin
      inflight.delete();
      m_ptr  = 0;
      m_last = '0;
    end else if (win >= 0) begin
      inflight.push_back('{g: cyc, idx: win, d: mem[waddr]});
      m_ptr = (win + 1) % NREQ;
    end
    cyc++;
  endtask

  function automatic logic [NREQ*AW-1:0] rnd_addr();
    return {$urandom, $urandom};
  endfunction

  initial begin
    checks = 0; errors = 0; cyc = 0; m_ptr = 0; m_last = '0;
    rst_n = 1'b0; lkp_en = 1'b1; req = '0; req_addr = '0;
    for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);
    mem[8'h3C] = 16'hBEEF;

    // Reset then idle.
    step(0, 1, 4'b0000, '0, 0);
    step(0, 1, 4'b0000, '0, 1);
    repeat (3) step(1, 1, 4'b0000, '0, 1);

    // Single lookup from requester 2 at address 3C.
    step(1, 1, 4'b0100, {8'h00, 8'h3C, 8'h00, 8'h00}, 1);
    repeat (3) step(1, 1, 4'b0000, rnd_addr(), 1);

    // Full contention: strict rotation, back-to-back responses.
    step(0, 1, 4'b0000, '0, 1);
    repeat (8) step(1, 1, 4'b1111, rnd_addr(), 1);
    repeat (3) step(1, 1, 4'b0000, '0, 1);

    // Fairness after a skip: move pointer to 3, then 3 and 0 compete.
    step(1, 1, 4'b0100, rnd_addr(), 1);
    repeat (2) step(1, 1, 4'b1001, rnd_addr(), 1);
    repeat (3) step(1, 1, 4'b0000, '0, 1);

    // lkp_en gating while a lookup drains.
    step(1, 1, 4'b0001, rnd_addr(), 1);
    repeat (3) step(1, 0, 4'b1111, rnd_addr(), 1);
    step(1, 1, 4'b0000, '0, 1);

    // Reset while a lookup is in flight; priority restarts at requester 0.
    step(1, 1, 4'b0010, rnd_addr(), 1);
    step(0, 1, 4'b0000, '0, 1);
    repeat (3) step(1, 1, 4'b1111, rnd_addr(), 1);
    repeat (3) step(1, 1, 4'b0000, '0, 1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0),
           NREQ'($urandom), rnd_addr(), 1);
    end
    repeat (4) step(1, 1, 4'b0000, '0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fwd_lkp_arb.md
Name: fwd_lkp_arb

Overview:
Round-robin arbiter that shares the single forwarding-lookup read port of the forwarding lookup table among NREQ ingress requesters.
- Issues at most one lookup per cycle.
- Tracks in-flight lookups through the table's fixed read latency.
- Returns each result to the requester that issued it.
- Sits between the per-port ingress parsers and the fwd_rden/fwd_addr/fwd_data port of the lookup block.
- A global enable lets host configuration freeze lookup traffic.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 8, lookup address width
DW, 16, lookup data width
RD_LAT, 1, table read latency in cycles, fwd_rden to valid fwd_data (1..4)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous reset, active low
lkp_en  input  1  1 = grants allowed; 0 = no new grants, in-flight lookups still complete
req  input  NREQ  per-requester lookup request, level
req_addr  input  NREQ*AW  per-requester address; requester i uses bits [i*AW +: AW]
gnt  output  NREQ  one-hot grant pulse; address consumed this cycle
rsp_vld  output  NREQ  one-hot response-valid pulse
rsp_data  output  DW  lookup result, qualified by rsp_vld
fwd_rden  output  1  read enable to the table forwarding port
fwd_addr  output  AW  read address to the table forwarding port
fwd_data  input  DW  read data from the table forwarding port
busy  output  1  1 while any lookup is in flight

Behaviour:
Reset (rst_n=0 at a clock edge):
- gnt=0, rsp_vld=0, rsp_data=0, busy=0.
- Round-robin pointer set to 0 (requester 0 has highest priority).
- Tag pipeline cleared.
- Lookups in flight at reset are dropped; no rsp_vld is ever produced for them.

Arbitration (combinational within the cycle):
- Eligible set = req & {NREQ{lkp_en}}.
- Winner = first eligible index scanning ptr, ptr+1, ... modulo NREQ.
- gnt[winner]=1 in the same cycle. fwd_rden = |gnt. fwd_addr = req_addr slice of the winner.
- With no grant, fwd_addr holds its last granted value.

Pointer:
- On a grant to i, ptr <= (i+1) mod NREQ at the clock edge.
- With no grant, ptr is unchanged.
- Any continuously requesting requester is granted within NREQ cycles.

Request protocol:
- Requester holds req and its address stable until it sees gnt.
- A req still high in the cycle after gnt is a new, independent lookup.
- Dropping req before gnt withdraws the request without side effects.

Tag pipeline:
- RD_LAT+1 stages, each holding {valid, index}.
- Stage 0 is loaded at the grant cycle's edge; each stage advances every cycle. No stall, no backpressure.
- rsp_data is registered from fwd_data when the tag reaches stage RD_LAT.
- rsp_vld[index] is asserted from the final stage.
- Latency is fixed: gnt at cycle N gives rsp_vld and rsp_data at cycle N+RD_LAT+1.
- rsp_data holds its last value when rsp_vld=0.
- Back-to-back grants give back-to-back responses in grant order, one per cycle.

busy: 1 when any tag stage is valid; registered.

lkp_en:
- Takes effect combinationally.
- When lkp_en falls, in-flight tags drain normally; busy lets the host wait for drain before writing the table.

Simultaneous events:
- All NREQ requesting gives strict rotation: 0,1,2,3,0...
- A single requester holding req gets a grant every cycle.

Test Plan:
- Reset then idle. Hold rst_n=0 for 2 cycles, req=0 -> gnt=0, rsp_vld=0, rsp_data=0, busy=0, fwd_rden=0 on every cycle after the reset edge.
- Single lookup, RD_LAT=1. req=4'b0100, addr2=8'h3C at cycle 10; table returns 16'hBEEF -> gnt=4'b0100 at cycle 10 only, fwd_addr=8'h3C, rsp_vld=4'b0100 and rsp_data=16'hBEEF at cycle 12.
- Full contention. All four req held high for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3; responses in the same order, one per cycle, starting 2 cycles after the first grant.
- Fairness after a skip. ptr=3 and req=4'b1001 -> gnt=4'b1000, then gnt=4'b0001 next cycle; requester 3 is not granted twice in a row while 0 waits.
- lkp_en gating and drain. Grant at cycle 20 with lkp_en=1, then lkp_en=0 at cycle 21 with req=4'b1111 -> no gnt from cycle 21; rsp_vld from the cycle-20 lookup appears at cycle 22; busy goes 0 at cycle 23.
- Reset mid-flight. Grant at cycle 30, rst_n=0 sampled at cycle 31 -> no rsp_vld at cycle 32, busy=0, ptr=0; the first grant after reset follows priority from requester 0.
